muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M multiply/divide unit (radix-2, IDLE/CALC/DONE) |
// | Optional macro MULDIV_FAST_MUL_EN : single-cycle 33x33 multiply path.      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [XLEN-1:0] c_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] c_ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] c_ZERO    = {XLEN{1'b0}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_f3;
  logic [4:0]       r_rd;
  // Shared datapath: multiply keeps {product_hi, product_lo/multiplier},
  // divide keeps {partial remainder, dividend/quotient}.
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_b;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_done;
  logic             r_wb_en;
  logic [XLEN-1:0]  r_result;
  logic [4:0]       r_wb_addr;

  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_sa;
  logic             w_sb;
  logic [XLEN-1:0]  w_mag_a;
  logic [XLEN-1:0]  w_mag_b;
  logic             w_div0;
  logic             w_ovf;
  logic [XLEN:0]    w_mul_sum;
  logic [XLEN:0]    w_div_shift;
  logic [XLEN+1:0]  w_div_diff;
  logic             w_div_ok;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]  w_quo_fix;
  logic [XLEN-1:0]  w_rem_fix;
  logic [XLEN-1:0]  w_res;

  // Divides: DIV/REM signed (funct3[0]=0). Multiplies: b signed only for MUL/MULH.
  assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_sa       = w_a_signed & operand_a[XLEN-1];
  assign w_sb       = w_b_signed & operand_b[XLEN-1];
  assign w_mag_a    = w_sa ? (c_ZERO - operand_a) : operand_a;
  assign w_mag_b    = w_sb ? (c_ZERO - operand_b) : operand_b;
  assign w_div0     = funct3[2] & (operand_b == c_ZERO);
  assign w_ovf      = funct3[2] & ~funct3[0] & (operand_a == c_MIN_INT) & (operand_b == c_ALL_ONE);

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]        w_fa;
  logic [XLEN:0]        w_fb;
  logic [2*XLEN+1:0]    w_fast_prod;

  assign w_fa        = {w_sa, operand_a};
  assign w_fb        = {w_sb, operand_b};
  assign w_fast_prod = $signed(w_fa) * $signed(w_fb);
`endif

  assign w_mul_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_ok    = ~w_div_diff[XLEN+1];

  assign w_prod      = {r_hi, r_lo};
  assign w_prod_fix  = r_neg_q ? ({(2*XLEN){1'b0}} - w_prod) : w_prod;
  assign w_quo_fix   = r_neg_q ? (c_ZERO - r_lo) : r_lo;
  assign w_rem_fix   = r_neg_r ? (c_ZERO - r_hi) : r_hi;

  always_comb begin
    w_res = c_ZERO;
    case (r_f3)
      3'b000:                 w_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = w_quo_fix;
      default:                w_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_f3      <= 3'b000;
      r_rd      <= 5'd0;
      r_hi      <= c_ZERO;
      r_lo      <= c_ZERO;
      r_b       <= c_ZERO;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_result  <= c_ZERO;
      r_wb_addr <= 5'd0;
    end else begin
      r_done  <= 1'b0;
      r_wb_en <= 1'b0;
      if (flush) begin
        r_state <= c_IDLE;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (start) begin
              r_f3  <= funct3;
              r_rd  <= rd_addr;
              r_cnt <= '0;
              if (w_div0) begin
                // Architectural results are returned raw, without sign fixup.
                r_lo    <= c_ALL_ONE;
                r_hi    <= operand_a;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_state <= c_DONE;
              end else if (w_ovf) begin
                r_lo    <= c_MIN_INT;
                r_hi    <= c_ZERO;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_state <= c_DONE;
`ifdef MULDIV_FAST_MUL_EN
              end else if (!funct3[2]) begin
                r_hi    <= w_fast_prod[2*XLEN-1:XLEN];
                r_lo    <= w_fast_prod[XLEN-1:0];
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_state <= c_DONE;
`endif
              end else begin
                r_hi    <= c_ZERO;
                r_lo    <= w_mag_a;
                r_b     <= w_mag_b;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_state <= c_CALC;
              end
            end
          end
          c_CALC: begin
            if (r_f3[2]) begin
              r_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_div_ok};
            end else begin
              r_hi <= w_mul_sum[XLEN:1];
              r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {CNT_W{1'b1}}) begin
              r_state <= c_DONE;
            end
          end
          c_DONE: begin
            r_result  <= w_res;
            r_wb_addr <= r_rd;
            r_done    <= 1'b1;
            r_wb_en   <= |r_rd;
            r_state   <= c_IDLE;
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign busy    = (r_state != c_IDLE);
  assign done    = r_done;
  assign wb_en   = r_wb_en;
  assign result  = r_result;
  assign wb_addr = r_wb_addr;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit : directed vectors with hand-computed RV32M results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wb_addr;
  logic        wb_en;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int c_MUL_LAT = 1;
`else
  localparam int c_MUL_LAT = 33;
`endif
  localparam int c_DIV_LAT  = 33;
  localparam int c_FAST_LAT = 1;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_addr   (rd_addr),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .wb_addr   (wb_addr),
    .wb_en     (wb_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one op, scramble the inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat,
                        output int bcyc, output logic wbe, output logic [4:0] wba);
    @(negedge clk);
    funct3 = f3; operand_a = a; operand_b = b; rd_addr = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    funct3 = 3'($urandom); rd_addr = 5'($urandom);
    lat = 0; bcyc = 0;
    while (!done && lat < 100) begin
      bcyc += int'(busy);
      @(negedge clk);
      lat++;
    end
    res = result; wbe = wb_en; wba = wb_addr;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    int          bcyc;
    logic        wbe;
    logic [4:0]  wba;
    run_op(f3, a, b, rd, res, lat, bcyc, wbe, wba);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bcyc), 32'(exp_lat));
    check({tag, "_wb_en"}, {31'd0, wbe}, {31'd0, rd != 5'd0});
    check({tag, "_wb_addr"}, {27'd0, wba}, {27'd0, rd});
  endtask

  initial begin
    int cnt;
    int ndone;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; operand_a = 32'd0; operand_b = 32'd0; rd_addr = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, busy},  32'd0);
    check("rst_done",    {31'd0, done},  32'd0);
    check("rst_wb_en",   {31'd0, wb_en}, 32'd0);
    check("rst_result",  result,         32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    reset = 1'b0;

    do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, c_MUL_LAT);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("wb_en_pulse", {31'd0, wb_en}, 32'd0);
    check("result_hold", result, 32'hFFFF_FFEB);

    do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, c_MUL_LAT);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, c_MUL_LAT);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF, c_MUL_LAT);
    do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD, c_DIV_LAT);
    do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, c_DIV_LAT);
    do_op("divu",   3'b101, 32'd100,       32'd7,         5'd7, 32'd14,        c_DIV_LAT);
    do_op("remu",   3'b111, 32'd100,       32'd7,         5'd8, 32'd2,         c_DIV_LAT);
    do_op("divu_z", 3'b101, 32'h1234,      32'd0,         5'd9, 32'hFFFF_FFFF, c_FAST_LAT);
    do_op("rem_z",  3'b110, 32'h1234,      32'd0,         5'd10, 32'h1234,     c_FAST_LAT);
    do_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, c_FAST_LAT);
    do_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        c_FAST_LAT);
    do_op("rd0",    3'b101, 32'd100,       32'd7,         5'd0, 32'd14,        c_DIV_LAT);

    // start pulsed while busy must be dropped, not queued
    @(negedge clk);
    funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; rd_addr = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    funct3 = 3'b000; operand_a = 32'd1; operand_b = 32'd1; rd_addr = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 5;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_ign_latency", 32'(cnt), 32'd33);
    check("busy_ign_result", result, 32'd14);
    check("busy_ign_wb_addr", {27'd0, wb_addr}, 32'd3);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("busy_ign_extra_done", 32'(ndone), 32'd0);

    // flush at cycle 10 of a DIV
    @(negedge clk);
    funct3 = 3'b100; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2; rd_addr = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", {31'd0, busy}, 32'd0);
    ndone = int'(done) + int'(wb_en);
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done) + int'(wb_en);
    end
    check("flush_no_done", 32'(ndone), 32'd0);

    // reset at cycle 20 of an operation, then a normal op
    @(negedge clk);
    funct3 = 3'b011; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF; rd_addr = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy",    {31'd0, busy},    32'd0);
    check("mid_rst_done",    {31'd0, done},    32'd0);
    check("mid_rst_wb_en",   {31'd0, wb_en},   32'd0);
    check("mid_rst_result",  result,           32'd0);
    check("mid_rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    do_op("after_rst", 3'b111, 32'd100, 32'd7, 5'd6, 32'd2, c_DIV_LAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
